// File: rtl/pb_spi_slave_pkg.sv
// pb_spi_slave_pkg
// Shared constants for the PicoBlaze SPI responder: register offsets within
// the four-port window, STATUS/CONTROL bit positions and the frame width.
package pb_spi_slave_pkg;

    localparam int SPI_BITS = 8;

    // Register offsets relative to BASE_ADDRESS
    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CONTROL = 2'd2,
        REG_CLEAR   = 2'd3
    } reg_sel_e;

    // STATUS bit positions (CLEAR uses the same positions for its W1C bits)
    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_BUSY     = 3;
    localparam int ST_UNDERRUN = 4;
    localparam int ST_CS_DONE  = 5;

    // CONTROL bit positions
    localparam int CTL_RX_IRQ  = 0;
    localparam int CTL_CS_IRQ  = 1;
    localparam int CTL_ERR_IRQ = 2;

endpackage

// File: rtl/pb_spi_slave_if.sv
// pb_spi_slave_if
// PicoBlaze port bus as seen by a peripheral.
//   port_id/data_in/read_strobe/write_strobe : processor -> peripheral
//   data_out/interrupt                       : peripheral -> processor
interface pb_spi_slave_if;
    logic [7:0] port_id;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read_strobe;
    logic       write_strobe;
    logic       interrupt;

    modport master (
        output port_id, data_in, read_strobe, write_strobe,
        input  data_out, interrupt
    );

    modport slave (
        input  port_id, data_in, read_strobe, write_strobe,
        output data_out, interrupt
    );
endinterface

// File: rtl/spi_slave_shift.sv
// spi_slave_shift
// SPI mode-0 bit engine: synchronises sck/ncs/mosi into clk, detects edges,
// counts bits and runs the RX and TX shift registers.
//   clk, reset   : system clock, synchronous active-high reset
//   sck_i, ncs_i, mosi_i : raw asynchronous SPI inputs
//   load_data    : byte to load into TX shift when load_req is high
//   byte_done    : one-cycle pulse, 8th sck rise of a byte; rx_byte valid then
//   load_req     : one-cycle pulse, TX shift register loads load_data
//   cs_rise      : one-cycle pulse, end of a frame that was properly started
//   busy         : synchronised ncs is low
//   miso         : TX shift MSB
module spi_slave_shift
    import pb_spi_slave_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sck_i,
    input  logic                ncs_i,
    input  logic                mosi_i,
    input  logic [SPI_BITS-1:0] load_data,
    output logic                byte_done,
    output logic [SPI_BITS-1:0] rx_byte,
    output logic                load_req,
    output logic                cs_rise,
    output logic                busy,
    output logic                miso
);

    localparam int CNT_W = $clog2(SPI_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_BITS - 1);

    // Bit order in the sync vectors: 2 = sck, 1 = ncs, 0 = mosi.
    // ncs resets high so an idle bus does not look like a frame start.
    localparam logic [2:0] SYNC_RST = 3'b010;

    logic [2:0] raw_in;
    logic [2:0] s1_reg, s2_reg, s3_reg;

    assign raw_in = {sck_i, ncs_i, mosi_i};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg[gi] <= SYNC_RST[gi];
                    s2_reg[gi] <= SYNC_RST[gi];
                    s3_reg[gi] <= SYNC_RST[gi];
                end else begin
                    s1_reg[gi] <= raw_in[gi];
                    s2_reg[gi] <= s1_reg[gi];
                    s3_reg[gi] <= s2_reg[gi];
                end
            end
        end
    endgenerate

    logic [1:0]          prime_cnt_reg;
    logic                frame_active_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [SPI_BITS-1:0] rx_shift_reg;
    logic [SPI_BITS-1:0] tx_shift_reg;

    logic edges_ok, sck_rise, sck_fall, ncs_fall, ncs_rise;

    // After reset the sync chain holds reset values rather than real bus
    // state; edges are only trusted once all three stages have refilled, so
    // a reset in the middle of a frame cannot fake an ncs falling edge.
    assign edges_ok = (prime_cnt_reg == 2'd3);
    assign ncs_fall = edges_ok & ~s2_reg[1] &  s3_reg[1];
    assign ncs_rise = edges_ok &  s2_reg[1] & ~s3_reg[1];
    // sck only matters inside a frame that began with a seen ncs fall.
    assign sck_rise = edges_ok & frame_active_reg &  s2_reg[2] & ~s3_reg[2];
    assign sck_fall = edges_ok & frame_active_reg & ~s2_reg[2] &  s3_reg[2];

    assign rx_byte   = {rx_shift_reg[SPI_BITS-2:0], s2_reg[0]};
    assign byte_done = sck_rise & (bit_cnt_reg == LAST_BIT);
    assign load_req  = ncs_fall | (sck_fall & (bit_cnt_reg == '0));
    assign cs_rise   = ncs_rise & frame_active_reg;
    assign busy      = ~s2_reg[1];
    assign miso      = tx_shift_reg[SPI_BITS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt_reg    <= '0;
            frame_active_reg <= 1'b0;
            bit_cnt_reg      <= '0;
            rx_shift_reg     <= '0;
            tx_shift_reg     <= '0;
        end else begin
            if (!edges_ok) begin
                prime_cnt_reg <= prime_cnt_reg + 2'd1;
            end

            if (ncs_fall) begin
                frame_active_reg <= 1'b1;
                bit_cnt_reg      <= '0;
            end else if (ncs_rise) begin
                // Partial byte simply abandoned; rx_shift is overwritten by
                // the next full byte anyway.
                frame_active_reg <= 1'b0;
                bit_cnt_reg      <= '0;
            end else if (sck_rise) begin
                rx_shift_reg <= rx_byte;
                bit_cnt_reg  <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + 1'b1;
            end

            if (load_req) begin
                tx_shift_reg <= load_data;
            end else if (sck_fall) begin
                tx_shift_reg <= {tx_shift_reg[SPI_BITS-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/pb_spi_slave.sv
// pb_spi_slave
// PicoBlaze-attached SPI responder: register file, flags and interrupt
// around the spi_slave_shift bit engine.
//   clk, reset      : system clock, synchronous active-high reset
//   bus (slave)     : PicoBlaze port bus (port_id, data_in, data_out,
//                     read_strobe, write_strobe, interrupt)
//   sck_i/ncs_i/mosi_i : SPI inputs from the remote master
//   miso_o, miso_oe : SPI data out and its enable (synchronised ncs low)
// Registers at BASE_ADDRESS+0..3: DATA, STATUS, CONTROL, CLEAR.
module pb_spi_slave
    import pb_spi_slave_pkg::*;
#(
    parameter logic [7:0] BASE_ADDRESS = 8'h00,
    parameter logic [7:0] IDLE_BYTE    = 8'hFF
) (
    input  logic           clk,
    input  logic           reset,
    pb_spi_slave_if.slave  bus,
    input  logic           sck_i,
    input  logic           ncs_i,
    input  logic           mosi_i,
    output logic           miso_o,
    output logic           miso_oe
);

    logic       byte_done, load_req, cs_rise, busy;
    logic [7:0] rx_byte, load_data;

    logic [7:0] rx_data_reg,   rx_data_next;
    logic       rx_valid_reg,  rx_valid_next;
    logic [7:0] tx_hold_reg,   tx_hold_next;
    logic       tx_empty_reg,  tx_empty_next;
    logic       overrun_reg,   overrun_next;
    logic       underrun_reg,  underrun_next;
    logic       cs_done_reg,   cs_done_next;
    logic [2:0] control_reg,   control_next;
    logic [7:0] data_out_reg,  data_out_next;
    logic       interrupt_reg, interrupt_next;

    logic [7:0] offset;
    logic       addr_hit;
    reg_sel_e   reg_sel;
    logic       rd_data, wr_data, wr_control, wr_clear;
    logic [7:0] status_vec;

    spi_slave_shift u_shift (
        .clk       (clk),
        .reset     (reset),
        .sck_i     (sck_i),
        .ncs_i     (ncs_i),
        .mosi_i    (mosi_i),
        .load_data (load_data),
        .byte_done (byte_done),
        .rx_byte   (rx_byte),
        .load_req  (load_req),
        .cs_rise   (cs_rise),
        .busy      (busy),
        .miso      (miso_o)
    );

    assign miso_oe   = busy;
    assign load_data = tx_empty_reg ? IDLE_BYTE : tx_hold_reg;

    assign offset     = bus.port_id - BASE_ADDRESS;
    assign addr_hit   = (offset[7:2] == 6'd0);
    assign reg_sel    = reg_sel_e'(offset[1:0]);
    assign rd_data    = bus.read_strobe  & addr_hit & (reg_sel == REG_DATA);
    assign wr_data    = bus.write_strobe & addr_hit & (reg_sel == REG_DATA);
    assign wr_control = bus.write_strobe & addr_hit & (reg_sel == REG_CONTROL);
    assign wr_clear   = bus.write_strobe & addr_hit & (reg_sel == REG_CLEAR);

    assign bus.data_out  = data_out_reg;
    assign bus.interrupt = interrupt_reg;

    always_comb begin
        rx_data_next  = rx_data_reg;
        rx_valid_next = rx_valid_reg;
        tx_hold_next  = tx_hold_reg;
        tx_empty_next = tx_empty_reg;
        overrun_next  = overrun_reg;
        underrun_next = underrun_reg;
        cs_done_next  = cs_done_reg;
        control_next  = control_reg;

        // Clears first so a flag event in the same cycle is not lost.
        if (wr_clear) begin
            if (bus.data_in[ST_OVERRUN])  overrun_next  = 1'b0;
            if (bus.data_in[ST_UNDERRUN]) underrun_next = 1'b0;
            if (bus.data_in[ST_CS_DONE])  cs_done_next  = 1'b0;
        end

        if (rd_data) begin
            rx_valid_next = 1'b0;
        end

        // A DATA read in the completing cycle frees the slot for the new byte.
        if (byte_done) begin
            if (!rx_valid_reg || rd_data) begin
                rx_data_next  = rx_byte;
                rx_valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end

        if (load_req) begin
            if (tx_empty_reg) begin
                underrun_next = 1'b1;
            end else begin
                tx_empty_next = 1'b1;
            end
        end

        // The load above already took the old holding value; a same-cycle
        // write is kept for the next load point.
        if (wr_data) begin
            tx_hold_next  = bus.data_in;
            tx_empty_next = 1'b0;
        end

        if (wr_control) begin
            control_next = bus.data_in[2:0];
        end

        if (cs_rise) begin
            cs_done_next = 1'b1;
        end

        status_vec              = 8'h00;
        status_vec[ST_RX_VALID] = rx_valid_reg;
        status_vec[ST_TX_EMPTY] = tx_empty_reg;
        status_vec[ST_OVERRUN]  = overrun_reg;
        status_vec[ST_BUSY]     = busy;
        status_vec[ST_UNDERRUN] = underrun_reg;
        status_vec[ST_CS_DONE]  = cs_done_reg;

        data_out_next = 8'h00;
        if (addr_hit) begin
            case (reg_sel)
                REG_DATA:    data_out_next = rx_data_reg;
                REG_STATUS:  data_out_next = status_vec;
                REG_CONTROL: data_out_next = {5'd0, control_reg};
                default:     data_out_next = 8'h00;
            endcase
        end

        // Built from next-state flags so the interrupt tracks them with one
        // register delay instead of two.
        interrupt_next = (control_next[CTL_RX_IRQ]  & rx_valid_next)
                       | (control_next[CTL_CS_IRQ]  & cs_done_next)
                       | (control_next[CTL_ERR_IRQ] & (overrun_next | underrun_next));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_reg   <= 8'h00;
            rx_valid_reg  <= 1'b0;
            tx_hold_reg   <= 8'h00;
            tx_empty_reg  <= 1'b1;
            overrun_reg   <= 1'b0;
            underrun_reg  <= 1'b0;
            cs_done_reg   <= 1'b0;
            control_reg   <= 3'd0;
            data_out_reg  <= 8'h00;
            interrupt_reg <= 1'b0;
        end else begin
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            tx_hold_reg   <= tx_hold_next;
            tx_empty_reg  <= tx_empty_next;
            overrun_reg   <= overrun_next;
            underrun_reg  <= underrun_next;
            cs_done_reg   <= cs_done_next;
            control_reg   <= control_next;
            data_out_reg  <= data_out_next;
            interrupt_reg <= interrupt_next;
        end
    end

endmodule

// File: tb/tb_pb_spi_slave.sv
// tb_pb_spi_slave
// Directed bench for pb_spi_slave: a behavioural mode-0 SPI master
// (sck = clk/8) and PicoBlaze-style register accesses, with hand-computed
// expected values. Every SPI byte ends with the sck falling edge, which is
// a byte-boundary load point, so frames that run out of TX data end with
// underrun set.
module tb_pb_spi_slave;

    localparam logic [7:0] A_DATA   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h01;
    localparam logic [7:0] A_CTRL   = 8'h02;
    localparam logic [7:0] A_CLEAR  = 8'h03;
    localparam logic [7:0] A_NONE   = 8'h80;

    logic clk;
    logic reset;
    logic sck_i, ncs_i, mosi_i;
    logic miso_o, miso_oe;

    int total;
    int bad;

    pb_spi_slave_if bus();

    pb_spi_slave #(
        .BASE_ADDRESS (8'h00),
        .IDLE_BYTE    (8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .sck_i   (sck_i),
        .ncs_i   (ncs_i),
        .mosi_i  (mosi_i),
        .miso_o  (miso_o),
        .miso_oe (miso_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bus helpers ----------------
    task automatic pb_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.port_id      = addr;
        bus.data_in      = data;
        bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
        bus.port_id      = A_NONE;
        $display("wr  addr=%h data=%h", addr, data);
    endtask

    task automatic pb_read(input logic [7:0] addr, output logic [7:0] data);
        @(negedge clk);
        bus.port_id     = addr;
        bus.read_strobe = 1'b1;
        @(posedge clk);
        #1;
        data            = bus.data_out;
        bus.read_strobe = 1'b0;
        bus.port_id     = A_NONE;
        $display("rd  addr=%h data=%h", addr, data);
    endtask

    // ---------------- SPI master helpers ----------------
    task automatic spi_start();
        @(negedge clk);
        ncs_i = 1'b0;
        #40;
    endtask

    task automatic spi_bit(input logic b, output logic m);
        mosi_i = b;
        #40;
        sck_i = 1'b1;
        m = miso_o;
        #40;
        sck_i = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], m);
            rx = {rx[6:0], m};
        end
        $display("spi mosi=%h miso=%h", tx, rx);
    endtask

    task automatic spi_end();
        #40;
        ncs_i = 1'b1;
        #80;
    endtask

    task automatic clear_all();
        pb_write(A_CLEAR, 8'h34);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.data_out !== 8'h00) begin
            bad++; $display("FAIL reset_data_out: got %h expected %h", bus.data_out, 8'h00);
        end
        total++;
        if (miso_oe !== 1'b0 || miso_o !== 1'b0 || bus.interrupt !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: got oe=%b miso=%b irq=%b expected 0 0 0",
                            miso_oe, miso_o, bus.interrupt);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        pb_read(A_STATUS, d);
        total++;
        if (d !== 8'h02) begin
            bad++; $display("FAIL reset_status: got %h expected %h", d, 8'h02);
        end
        pb_read(8'h07, d);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL unmapped_port: got %h expected %h", d, 8'h00);
        end
    endtask

    task automatic test_basic_xfer();
        logic [7:0] d, r;
        pb_write(A_DATA, 8'hA5);
        pb_read(A_STATUS, d);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL basic_status_loaded: got %h expected %h", d, 8'h00);
        end
        spi_start();
        total++;
        if (miso_oe !== 1'b1) begin
            bad++; $display("FAIL basic_miso_oe: got %b expected 1", miso_oe);
        end
        spi_byte(8'h3C, r);
        spi_end();
        total++;
        if (r !== 8'hA5) begin
            bad++; $display("FAIL basic_master_rx: got %h expected %h", r, 8'hA5);
        end
        pb_read(A_STATUS, d);
        total++;
        if (d !== 8'h33) begin
            bad++; $display("FAIL basic_status_after: got %h expected %h", d, 8'h33);
        end
        pb_read(A_DATA, d);
        total++;
        if (d !== 8'h3C) begin
            bad++; $display("FAIL basic_rx_data: got %h expected %h", d, 8'h3C);
        end
        clear_all();
        pb_read(A_STATUS, d);
        total++;
        if (d !== 8'h02) begin
            bad++; $display("FAIL basic_status_clean: got %h expected %h", d, 8'h02);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d, r0, r1;
        spi_start();
        spi_byte(8'h11, r0);
        spi_byte(8'h22, r1);
        spi_end();
        total++;
        if (r0 !== 8'hFF || r1 !== 8'hFF) begin
            bad++; $display("FAIL ovr_idle_bytes: got %h %h expected ff ff", r0, r1);
        end
        pb_read(A_STATUS, d);
        total++;
        if (d !== 8'h37) begin
            bad++; $display("FAIL ovr_status: got %h expected %h", d, 8'h37);
        end
        pb_write(A_CLEAR, 8'h14);
        pb_read(A_STATUS, d);
        total++;
        if (d !== 8'h23) begin
            bad++; $display("FAIL ovr_status_cleared: got %h expected %h", d, 8'h23);
        end
        pb_read(A_DATA, d);
        total++;
        if (d !== 8'h11) begin
            bad++; $display("FAIL ovr_rx_first_kept: got %h expected %h", d, 8'h11);
        end
        clear_all();
    endtask

    task automatic test_interrupt();
        logic [7:0] d, r;
        logic m;
        logic seen;
        logic [7:0] pattern;
        pattern = 8'h5A;
        pb_write(A_CTRL, 8'h01);
        pb_read(A_CTRL, d);
        total++;
        if (d !== 8'h01) begin
            bad++; $display("FAIL irq_ctrl_readback: got %h expected %h", d, 8'h01);
        end
        spi_start();
        for (int i = 7; i >= 1; i--) begin
            spi_bit(pattern[i], m);
        end
        mosi_i = pattern[0];
        #40;
        total++;
        if (bus.interrupt !== 1'b0) begin
            bad++; $display("FAIL irq_early: got %b expected 0", bus.interrupt);
        end
        sck_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #10;
            if (bus.interrupt === 1'b1) seen = 1'b1;
        end
        sck_i = 1'b0;
        total++;
        if (seen !== 1'b1) begin
            bad++; $display("FAIL irq_latency: got %b expected 1 within 4 clk", seen);
        end
        spi_end();
        total++;
        if (bus.interrupt !== 1'b1) begin
            bad++; $display("FAIL irq_held: got %b expected 1", bus.interrupt);
        end
        pb_read(A_DATA, r);
        total++;
        if (r !== 8'h5A || bus.interrupt !== 1'b0) begin
            bad++; $display("FAIL irq_fall_on_read: got data=%h irq=%b expected 5a 0", r, bus.interrupt);
        end
        // Error interrupt: this frame left underrun set.
        pb_write(A_CTRL, 8'h04);
        @(negedge clk);
        total++;
        if (bus.interrupt !== 1'b1) begin
            bad++; $display("FAIL irq_error: got %b expected 1", bus.interrupt);
        end
        clear_all();
        @(negedge clk);
        total++;
        if (bus.interrupt !== 1'b0) begin
            bad++; $display("FAIL irq_error_cleared: got %b expected 0", bus.interrupt);
        end
        pb_write(A_CTRL, 8'h00);
    endtask

    task automatic test_abort();
        logic [7:0] d, r;
        logic m;
        spi_start();
        for (int i = 0; i < 5; i++) begin
            spi_bit(i[0], m);
        end
        spi_end();
        pb_read(A_STATUS, d);
        total++;
        if (d !== 8'h32) begin
            bad++; $display("FAIL abort_status_partial: got %h expected %h", d, 8'h32);
        end
        clear_all();
        spi_start();
        spi_byte(8'hC3, r);
        spi_end();
        pb_read(A_STATUS, d);
        total++;
        if (d !== 8'h33) begin
            bad++; $display("FAIL abort_status_full: got %h expected %h", d, 8'h33);
        end
        pb_read(A_DATA, d);
        total++;
        if (d !== 8'hC3) begin
            bad++; $display("FAIL abort_rx_data: got %h expected %h", d, 8'hC3);
        end
        clear_all();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d, r;
        logic m;
        pb_write(A_CTRL, 8'h07);
        spi_start();
        for (int i = 0; i < 3; i++) begin
            spi_bit(1'b1, m);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        pb_read(A_STATUS, d);
        total++;
        if (d !== 8'h0A) begin
            bad++; $display("FAIL midrst_status_busy: got %h expected %h", d, 8'h0A);
        end
        pb_read(A_CTRL, d);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL midrst_ctrl: got %h expected %h", d, 8'h00);
        end
        // Rest of the interrupted frame must be ignored entirely.
        for (int i = 0; i < 5; i++) begin
            spi_bit(1'b0, m);
        end
        spi_end();
        pb_read(A_STATUS, d);
        total++;
        if (d !== 8'h02) begin
            bad++; $display("FAIL midrst_status_ignored: got %h expected %h", d, 8'h02);
        end
        spi_start();
        spi_byte(8'h81, r);
        spi_end();
        total++;
        if (r !== 8'hFF) begin
            bad++; $display("FAIL midrst_master_rx: got %h expected %h", r, 8'hFF);
        end
        pb_read(A_STATUS, d);
        total++;
        if (d !== 8'h33) begin
            bad++; $display("FAIL midrst_status_frame: got %h expected %h", d, 8'h33);
        end
        pb_read(A_DATA, d);
        total++;
        if (d !== 8'h81) begin
            bad++; $display("FAIL midrst_rx_data: got %h expected %h", d, 8'h81);
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset            = 1'b1;
        sck_i            = 1'b0;
        ncs_i            = 1'b1;
        mosi_i           = 1'b0;
        bus.port_id      = A_NONE;
        bus.data_in      = 8'h00;
        bus.read_strobe  = 1'b0;
        bus.write_strobe = 1'b0;

        test_reset();
        test_basic_xfer();
        test_overrun();
        test_interrupt();
        test_abort();
        test_reset_midframe();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
